// File: rtl/matrix_mac_pkg.sv
// Shared defaults, FSM encoding and index types for the matrix operand feeder.
// Optional MAC stall support is enabled with the MATRIX_FEEDER_STALL_EN macro.
package matrix_mac_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32'd8;
    localparam int unsigned DEFAULT_DIM        = 32'd4;
    localparam int unsigned MAX_DIM            = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

    // Sized for the largest legal DIM so one type serves every configuration.
    typedef logic [$clog2(MAX_DIM)-1:0]         dim_idx_t;
    typedef logic [$clog2(MAX_DIM*MAX_DIM)-1:0] elem_addr_t;

    function automatic elem_addr_t elem_addr(input dim_idx_t row, input dim_idx_t col,
                                             input int unsigned dim);
        int unsigned flat;
        flat = 32'(row) * dim + 32'(col);
        return elem_addr_t'(flat);
    endfunction

endpackage

// File: rtl/matrix_operand_bank.sv
// Two DIM*DIM operand register banks (A and B) with a shared write port and one
// combinational read port per bank. Contents are deliberately never reset.
module matrix_operand_bank
    import matrix_mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DIM        = DEFAULT_DIM
) (
    input  logic                          clock,
    input  logic                          wr_en,
    input  logic                          wr_sel,
    input  logic [$clog2(DIM*DIM)-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  elem_addr_t                    rd_a_addr,
    output logic [DATA_WIDTH-1:0]         rd_a_data,
    input  elem_addr_t                    rd_b_addr,
    output logic [DATA_WIDTH-1:0]         rd_b_data
);

    localparam int unsigned NUM_ELEMS = DIM * DIM;
    localparam int unsigned AW        = $clog2(DIM * DIM);
    typedef logic [AW-1:0] addr_t;

    logic [DATA_WIDTH-1:0] bank_a_r [NUM_ELEMS];
    logic [DATA_WIDTH-1:0] bank_b_r [NUM_ELEMS];

    // Element write into the selected bank; addresses past the matrix are dropped.
    always_ff @(posedge clock) begin
        if (wr_en && (32'(wr_addr) < NUM_ELEMS)) begin
            if (wr_sel) begin
                bank_b_r[wr_addr] <= wr_data;
            end else begin
                bank_a_r[wr_addr] <= wr_data;
            end
        end
    end

    // Bank A read port; out-of-range addresses read as zero.
    always_comb begin
        rd_a_data = '0;
        if (32'(rd_a_addr) < NUM_ELEMS) begin
            rd_a_data = bank_a_r[addr_t'(rd_a_addr)];
        end else begin
            rd_a_data = '0;
        end
    end

    // Bank B read port; out-of-range addresses read as zero.
    always_comb begin
        rd_b_data = '0;
        if (32'(rd_b_addr) < NUM_ELEMS) begin
            rd_b_data = bank_b_r[addr_t'(rd_b_addr)];
        end else begin
            rd_b_data = '0;
        end
    end

endmodule

// File: rtl/matrix_operand_feeder.sv
// Streams A[i][k]/B[k][j] operand pairs to an external MAC to form C=A*B in row-major order.
// Define MATRIX_FEEDER_STALL_EN to add the mac_stall back-pressure input.
module matrix_operand_feeder
    import matrix_mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DIM        = DEFAULT_DIM
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic                          wr_sel,
    input  logic [$clog2(DIM*DIM)-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          start,
`ifdef MATRIX_FEEDER_STALL_EN
    input  logic                          mac_stall,
`endif
    output logic                          busy,
    output logic                          done,
    output logic                          mac_enable,
    output logic                          mac_clear,
    output logic [DATA_WIDTH-1:0]         operand_a,
    output logic [DATA_WIDTH-1:0]         operand_b,
    output logic                          result_strobe,
    output logic [$clog2(DIM*DIM)-1:0]    result_index
);

    localparam int unsigned AW       = $clog2(DIM * DIM);
    localparam dim_idx_t    LAST_IDX = dim_idx_t'(DIM - 32'd1);
    localparam dim_idx_t    IDX_ONE  = dim_idx_t'(32'd1);
    typedef logic [AW-1:0] addr_t;

    feeder_state_e         state_r, state_s;
    dim_idx_t              i_r, j_r, k_r;
    dim_idx_t              i_s, j_s, k_s;
    logic                  elem_last_s;
    logic                  stall_s;
    logic                  bank_wr_en_s;
    elem_addr_t            rd_a_addr_s, rd_b_addr_s;
    logic [DATA_WIDTH-1:0] rd_a_data_s, rd_b_data_s;

    logic                  busy_r, done_r, mac_enable_r, mac_clear_r, result_strobe_r;
    logic [DATA_WIDTH-1:0] operand_a_r, operand_b_r;
    addr_t                 result_index_r;

`ifdef MATRIX_FEEDER_STALL_EN
    assign stall_s    = mac_stall;
    assign mac_enable = mac_enable_r && !mac_stall;
`else
    assign stall_s    = 1'b0;
    assign mac_enable = mac_enable_r;
`endif

    // Bank is writable only while idle so operands cannot change under a running job.
    assign bank_wr_en_s = wr_en && !reset && (state_r == ST_IDLE);

    // Operands are fetched for the upcoming cycle so they can be registered.
    assign rd_a_addr_s = elem_addr(i_s, k_s, DIM);
    assign rd_b_addr_s = elem_addr(k_s, j_s, DIM);

    matrix_operand_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIM        (DIM)
    ) u_bank (
        .clock      (clock),
        .wr_en      (bank_wr_en_s),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_a_addr  (rd_a_addr_s),
        .rd_a_data  (rd_a_data_s),
        .rd_b_addr  (rd_b_addr_s),
        .rd_b_data  (rd_b_data_s)
    );

    // Next-state and loop-index sequencing.
    always_comb begin
        state_s     = state_r;
        i_s         = i_r;
        j_s         = j_r;
        k_s         = k_r;
        elem_last_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_CLEAR;
                    i_s     = '0;
                    j_s     = '0;
                    k_s     = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (stall_s) begin
                    state_s = ST_STREAM;
                end else if (k_r != LAST_IDX) begin
                    k_s = k_r + IDX_ONE;
                end else begin
                    k_s         = '0;
                    elem_last_s = 1'b1;
                    if (j_r != LAST_IDX) begin
                        j_s     = j_r + IDX_ONE;
                        state_s = ST_CLEAR;
                    end else begin
                        j_s = '0;
                        if (i_r != LAST_IDX) begin
                            i_s     = i_r + IDX_ONE;
                            state_s = ST_CLEAR;
                        end else begin
                            i_s     = '0;
                            state_s = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and loop-index registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
        end else begin
            state_r <= state_s;
            i_r     <= i_s;
            j_r     <= j_s;
            k_r     <= k_s;
        end
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            mac_enable_r    <= 1'b0;
            mac_clear_r     <= 1'b0;
            operand_a_r     <= '0;
            operand_b_r     <= '0;
            result_strobe_r <= 1'b0;
            result_index_r  <= '0;
        end else begin
            busy_r          <= (state_s != ST_IDLE);
            done_r          <= (state_s == ST_DONE);
            mac_enable_r    <= (state_s == ST_STREAM);
            mac_clear_r     <= (state_s == ST_CLEAR);
            operand_a_r     <= (state_s == ST_STREAM) ? rd_a_data_s : '0;
            operand_b_r     <= (state_s == ST_STREAM) ? rd_b_data_s : '0;
            result_strobe_r <= elem_last_s;
            result_index_r  <= elem_last_s ? addr_t'(elem_addr(i_r, j_r, DIM)) : '0;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign mac_clear     = mac_clear_r;
    assign operand_a     = operand_a_r;
    assign operand_b     = operand_b_r;
    assign result_strobe = result_strobe_r;
    assign result_index  = result_index_r;

endmodule

// File: doc/matrix_operand_feeder.md
MATRIX_OPERAND_FEEDER -- requirements
Module: matrix_operand_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand element width in bits.
REQ-002 SHALL have parameter DIM, default 4: square matrix dimension, legal range 2..16.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clock, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port wr_en, input, 1: operand bank write strobe.
REQ-007 SHALL have port wr_sel, input, 1: bank select, 0=A, 1=B.
REQ-008 SHALL have port wr_addr, input, clog2(DIM*DIM): row-major element address, row*DIM+col.
REQ-009 SHALL have port wr_data, input, DATA_WIDTH: element to write.
REQ-010 SHALL have port start, input, 1: single-cycle request to begin C=A*B streaming.
REQ-011 SHALL have port busy, output, 1: high from start acceptance until done.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port mac_enable, output, 1: MAC accumulate strobe.
REQ-014 SHALL have port mac_clear, output, 1: MAC accumulator clear strobe.
REQ-015 SHALL have port operand_a, output, DATA_WIDTH: A element to MAC matrix_1.
REQ-016 SHALL have port operand_b, output, DATA_WIDTH: B element to MAC matrix_2.
REQ-017 SHALL have port result_strobe, output, 1: MAC result for result_index is valid this cycle.
REQ-018 SHALL have port result_index, output, clog2(DIM*DIM): row-major C index i*DIM+j.

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR, STREAM, DONE.
REQ-020 SHALL write wr_data into the selected bank at wr_addr on wr_en only in IDLE; writes in any other state are ignored.
REQ-021 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-022 IDLE->CLEAR on start; CLEAR->STREAM after 1 cycle; STREAM->CLEAR after DIM enabled cycles if elements remain, else ->DONE; DONE->IDLE after 1 cycle.
REQ-023 SHALL, for C element (i,j) in row-major order, assert mac_clear for exactly 1 CLEAR cycle, then mac_enable for DIM cycles with operand_a=A[i][k], operand_b=B[k][j], k=0..DIM-1.
REQ-024 SHALL drive operand_a/operand_b to 0 and mac_enable low outside STREAM.
REQ-025 SHALL pulse result_strobe for 1 cycle in the cycle after the last k of each element, with result_index=i*DIM+j of that element (coincides with next CLEAR or DONE).
REQ-026 With start accepted at edge T, done SHALL be high in cycle T+1+DIM*DIM*(DIM+1) (T+81 for DIM=4), absent stalls.
REQ-027 busy SHALL be high in CLEAR, STREAM, DONE; low in IDLE.
REQ-028 Indices i, j, k SHALL wrap to 0 at DIM; no out-of-range bank reads.
REQ-029 mac_clear and mac_enable SHALL never be high in the same cycle.

Reset
REQ-030 Reset SHALL force IDLE and zero busy, done, mac_enable, mac_clear, operand_a, operand_b, result_strobe, result_index, i, j, k, overriding all other inputs, including mid-stream.
REQ-031 Reset SHALL NOT clear operand bank contents.

Configuration
REQ-032 With MATRIX_FEEDER_STALL_EN defined, SHALL add input mac_stall (1 bit): while high in STREAM, mac_enable low, k and operands held, state held; CLEAR/DONE unaffected.
REQ-033 Without MATRIX_FEEDER_STALL_EN, SHALL have no mac_stall port and timing SHALL be exactly REQ-026.

Structure
REQ-034 Package matrix_mac_pkg SHALL hold default DATA_WIDTH, DIM, the FSM state enum and index typedefs.
REQ-035 SHALL instantiate sub-module matrix_operand_bank: two DIM*DIM register banks, one write port, two combinational read ports.

Verification
REQ-036 A=identity, B[r][c]=r*4+c, start -> for index 6 (i=1,j=2) operand pairs (0,2),(1,6),(0,10),(0,14); result_strobe indices 0..15 in order; done at T+81.
REQ-037 start re-asserted at T+10 -> ignored; done still single pulse at T+81.
REQ-038 wr_en to A[0]=0xFF at T+5 during busy -> A[0] unchanged after done.
REQ-039 reset at T+30 -> next cycle IDLE, all outputs 0; new start streams from index 0 with bank contents intact.
REQ-040 MATRIX_FEEDER_STALL_EN, mac_stall high 3 cycles mid-STREAM -> mac_enable low those cycles, operands held, done at T+84.
REQ-041 Every cycle assert mac_clear&&mac_enable==0 and count mac_enable=DIM per result_strobe.
